avalon_mm_mult_slave_v2: RTL and testbench
==========================================

# avalon_mm_mult_slave_v2

Parametrised Avalon-MM slave that wraps a sequential shift-add unsigned multiplier behind a word-addressed register map. Successor to the fixed 32-bit, 16-bit-bus multiplier slave, adding the following:
- generic operand and bus widths;
- an explicit start/status handshake;
- `waitrequest` stalling while the multiplier is busy;
- registered read data qualified by `readdatavalid`;
- an optional completion interrupt.

It sits between an Avalon-MM master (bus FSM or interconnect) and the arithmetic datapath.

## Interface
- SZ, 32, operand width in bits; must be a multiple of DW.
- DW, 16, Avalon data-bus width in bits.
- AW, 4, address width in words; must satisfy 2^AW ≥ 4·(SZ/DW)+2.
- clk  in  1  single clock; all logic on rising edge.
- _rst  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- addr  in  AW  word address.
- read  in  1  read request.
- write  in  1  write request.
- write_data  in  DW  write data.
- read_data  out  DW  registered read data.
- readdatavalid  out  1  one-cycle pulse qualifying read_data.
- waitrequest  out  1  combinational stall; the request is held by the master while high.
- irq  out  1  level interrupt, equal to done & irq_en.

## Operation
- Let NA = SZ/DW. The register map uses the following word addresses:
  - A word i: address i, for i = 0..NA-1; read/write.
  - B word i: address NA+i; read/write.
  - RES word j: address 2NA+j, for j = 0..2NA-1; read-only; word 0 is the least significant.
  - CTRL: address 4NA.
    - Bit 0, start: write-1-to-start; self-clearing; reads as 0.
    - Bit 1, done_clr: write-1 clears done.
    - Bit 2, irq_en: read/write.
  - STATUS: address 4NA+1; read-only. Bit 0 is busy and bit 1 is done; all other bits are 0.
- FSM states: IDLE and BUSY.
  - IDLE → BUSY on an accepted CTRL write with bit 0 = 1.
    - On that edge: latch A and B into working registers, clear the 2·SZ-bit accumulator, set count to 0, and clear done.
  - BUSY: each edge performs one iteration.
    - If multiplier bit 0 = 1, add the multiplicand into the accumulator.
    - Shift the multiplicand left and the multiplier right.
    - Increment count.
  - BUSY → IDLE on the edge that completes iteration SZ. On that edge, RES is loaded with the full 2·SZ-bit product and done is set.
- RES holds the previous product throughout BUSY, and holds its value until the next completion. The product is exact unsigned SZ×SZ → 2·SZ; there is no truncation.
- A start written while BUSY is stalled (see waitrequest). A start written in IDLE with done already set restarts the multiplier and clears done.
- If done_clr and start are written in the same word, start wins: done clears and a new operation begins.
- If read and write are asserted together, the access is treated as a read and the write is discarded.
- A read of an unmapped address returns 0. A write to an unmapped address, RES or STATUS is ignored.
- Partial writes are not supported; every write updates a whole DW-bit word.

## Timing
- waitrequest = BUSY & (read | write) & (addr ≠ STATUS). A STATUS read is never stalled.
- A request is accepted on an edge where (read | write) & !waitrequest.
- Read latency is fixed at 1. read_data and readdatavalid update on the accepting edge and are visible in the following cycle. readdatavalid is 0 in every other cycle, and read_data holds its last value.
- Writes take effect on the accepting edge.
- Start accepted at edge E0 → BUSY during edges E1..ESZ. done = 1 and RES is valid after ESZ.
- The earliest RES read accepted is at E(SZ+1), with data in the cycle after that. Start-to-result is SZ+2 cycles.
- irq rises in the cycle after ESZ, provided irq_en = 1.
- Back-to-back accepted accesses are allowed every cycle with no bubbles while IDLE.
- Reset behaviour (_rst low at an edge):
  - state returns to IDLE; A, B, RES, the working registers, count, done and irq_en are cleared to 0.
  - read_data = 0, readdatavalid = 0, irq = 0, and waitrequest = 0 (it is combinational off IDLE).
  - A reset in mid-BUSY aborts the operation; no done and no RES update follow.

## Test plan
- **Basic product:** SZ=32, DW=16. Write A=0x0000_0003, B=0x0000_0005, then start. Poll STATUS until done → RES words 0..3 read 0x000F, 0, 0, 0, each with a readdatavalid pulse.
- **Full width:** A=B=0xFFFF_FFFF → RES = 0xFFFF_FFFE_0000_0001. done is set exactly 32 edges after the start edge.
- **Stall:** issue a RES[0] read one cycle after start → waitrequest high for 32 cycles. The read is accepted at E33 and returns the new product low word.
  - A STATUS read issued during BUSY returns 0x0001 with no stall.
- **Interrupt and clear:** with irq_en=1, irq rises after completion. A CTRL write of 0x0006 drops irq next cycle. A CTRL write of 0x0005 restarts the multiplier and keeps irq_en set.
- **Reset mid-operation:** pull _rst low for 1 cycle at BUSY iteration 10 → STATUS reads 0x0000, RES reads 0, and irq = 0.
- **Edge cases:**
  - A read of address 15 returns 0x0000.
  - read and write asserted together to A[0] → read returns the old value and A is unchanged.
  - SZ=64, DW=32, AW=4 with A=2^63, B=2 → RES = 2^64.

Source files
------------

// File: rtl/avalon_mm_mult_slave_v2_if.sv
// Avalon-MM bus bundle for the multiplier slave.
// The master drives requests; the slave answers with stall and read data.
interface avalon_mm_mult_slave_v2_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic [AW-1:0] addr;
    logic          read;
    logic          write;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          readdatavalid;
    logic          waitrequest;

    modport master (
        output addr, read, write, write_data,
        input  read_data, readdatavalid, waitrequest
    );

    modport slave (
        input  addr, read, write, write_data,
        output read_data, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_mm_mult_slave_v2.sv
// Avalon-MM slave around a shift-add SZ x SZ unsigned multiplier.
// Registered reads (latency 1), stalls while busy, optional done interrupt.
module avalon_mm_mult_slave_v2 #(
    parameter int SZ = 32,
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic clk,
    input  logic _rst,
    avalon_mm_mult_slave_v2_if.slave bus,
    output logic irq
);
    localparam int NA = SZ / DW;
    localparam int CW = $clog2(SZ + 1);
    localparam logic [AW-1:0] CTRL_ADDR = AW'(4 * NA);
    localparam logic [AW-1:0] STAT_ADDR = AW'(4 * NA + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;

    logic [SZ-1:0]   a_reg, b_reg, mplier;
    logic [2*SZ-1:0] res_reg, mcand, acc, acc_sum;
    logic [CW-1:0]   count;
    logic            done, irq_en;
    logic            req, accept, rd_acc, wr_acc;
    logic            ctrl_wr, start, last_iter;
    logic [DW-1:0]   rd_mux, rd_data_q;
    logic            rdv_q;

    assign req = bus.read | bus.write;
    // STATUS stays readable while busy so software can poll
    assign bus.waitrequest = (state == BUSY) & req
                           & (bus.addr != STAT_ADDR);
    assign accept = req & ~bus.waitrequest;
    assign rd_acc = accept & bus.read;
    assign wr_acc = accept & bus.write & ~bus.read;
    assign ctrl_wr = wr_acc & (bus.addr == CTRL_ADDR);
    assign start = ctrl_wr & bus.write_data[0];
    assign last_iter = (state == BUSY) & (count == CW'(SZ - 1));
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    assign irq = done & irq_en;
    assign bus.read_data = rd_data_q;
    assign bus.readdatavalid = rdv_q;

    always_ff @(posedge clk) begin
        if (!_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NA; i++) begin
            if (bus.addr == AW'(i))
                rd_mux = a_reg[i*DW +: DW];
            if (bus.addr == AW'(NA + i))
                rd_mux = b_reg[i*DW +: DW];
        end
        for (int j = 0; j < 2 * NA; j++) begin
            if (bus.addr == AW'(2 * NA + j))
                rd_mux = res_reg[j*DW +: DW];
        end
        if (bus.addr == CTRL_ADDR)
            rd_mux[2] = irq_en;
        if (bus.addr == STAT_ADDR) begin
            rd_mux[0] = (state == BUSY);
            rd_mux[1] = done;
        end
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            rd_data_q <= '0;
            rdv_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                for (int i = 0; i < NA; i++) begin
                    if (bus.addr == AW'(i))
                        a_reg[i*DW +: DW] <= bus.write_data;
                    if (bus.addr == AW'(NA + i))
                        b_reg[i*DW +: DW] <= bus.write_data;
                end
            end
            if (ctrl_wr)
                irq_en <= bus.write_data[2];
            // start outranks done_clr when both are written together
            if (start) begin
                mcand  <= {{SZ{1'b0}}, a_reg};
                mplier <= b_reg;
                acc    <= '0;
                count  <= '0;
                done   <= 1'b0;
            end else if (state == BUSY) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (last_iter) begin
                    res_reg <= acc_sum;
                    done    <= 1'b1;
                end
            end else if (ctrl_wr && bus.write_data[1]) begin
                done <= 1'b0;
            end
            if (rd_acc) begin
                rd_data_q <= rd_mux;
                rdv_q     <= 1'b1;
            end else begin
                rdv_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_avalon_mm_mult_slave_v2.sv
// Directed bench for avalon_mm_mult_slave_v2 (32/16 and 64/32 builds).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_avalon_mm_mult_slave_v2;
    logic clk = 1'b0;
    logic _rst = 1'b0;
    logic irq0, irq1;
    int checks = 0;
    int errors = 0;

    avalon_mm_mult_slave_v2_if #(.AW(4), .DW(16)) bus0 ();
    avalon_mm_mult_slave_v2_if #(.AW(4), .DW(32)) bus1 ();

    avalon_mm_mult_slave_v2 #(.SZ(32), .DW(16), .AW(4)) dut0 (
        .clk(clk), ._rst(_rst), .bus(bus0.slave), .irq(irq0)
    );

    avalon_mm_mult_slave_v2 #(.SZ(64), .DW(32), .AW(4)) dut1 (
        .clk(clk), ._rst(_rst), .bus(bus1.slave), .irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d,
                      output int stalls);
        bit ok = 0;
        logic w;
        stalls = 0;
        bus0.addr = a;
        bus0.write = 1'b1;
        bus0.read = 1'b0;
        bus0.write_data = d;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1 w = bus0.waitrequest;
            @(posedge clk);
            if (!w) ok = 1;
            else stalls++;
            @(negedge clk);
        end
        if (!ok) check("wr_timeout", 64'd1, 64'd0);
        bus0.write = 1'b0;
    endtask

    task automatic rdx(input logic [3:0] a, input bit also_wr,
                       output logic [15:0] d, output int stalls);
        bit ok = 0;
        logic w;
        stalls = 0;
        d = '0;
        bus0.addr = a;
        bus0.read = 1'b1;
        bus0.write = also_wr;
        bus0.write_data = 16'h1111;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1 w = bus0.waitrequest;
            @(posedge clk);
            if (!w) ok = 1;
            else stalls++;
            @(negedge clk);
        end
        if (!ok) check("rd_timeout", 64'd1, 64'd0);
        check("rdv_pulse", 64'(bus0.readdatavalid), 64'd1);
        d = bus0.read_data;
        bus0.read = 1'b0;
        bus0.write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        int s;
        rdx(a, 1'b0, d, s);
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] d);
        bus1.addr = a;
        bus1.write = 1'b1;
        bus1.write_data = d;
        @(negedge clk);
        bus1.write = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] a, output logic [31:0] d);
        bus1.addr = a;
        bus1.read = 1'b1;
        @(negedge clk);
        check("rdv1_pulse", 64'(bus1.readdatavalid), 64'd1);
        d = bus1.read_data;
        bus1.read = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic [31:0] d1;
        int s, n;
        bit seen;

        bus0.addr = '0; bus0.read = 0; bus0.write = 0; bus0.write_data = '0;
        bus1.addr = '0; bus1.read = 0; bus1.write = 0; bus1.write_data = '0;
        repeat (2) @(negedge clk);
        check("rst_rdata", 64'(bus0.read_data), 64'd0);
        check("rst_rdv", 64'(bus0.readdatavalid), 64'd0);
        check("rst_wait", 64'(bus0.waitrequest), 64'd0);
        check("rst_irq", 64'(irq0), 64'd0);
        check("rst_rdata1", 64'(bus1.read_data), 64'd0);
        _rst = 1'b1;
        @(negedge clk);
        rd(4'd9, d);
        check("rst_status", 64'(d), 64'h0);

        // basic product 3 * 5
        wr(4'd0, 16'h0003, s);
        wr(4'd1, 16'h0000, s);
        wr(4'd2, 16'h0005, s);
        wr(4'd3, 16'h0000, s);
        rd(4'd0, d);
        check("a0_readback", 64'(d), 64'h3);
        wr(4'd8, 16'h0001, s);
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            rd(4'd9, d);
            if (d[1]) seen = 1;
        end
        check("basic_done", 64'(seen), 64'd1);
        check("basic_status", 64'(d), 64'h2);
        rd(4'd4, d); check("basic_res0", 64'(d), 64'h000F);
        rd(4'd5, d); check("basic_res1", 64'(d), 64'h0);
        rd(4'd6, d); check("basic_res2", 64'(d), 64'h0);
        rd(4'd7, d); check("basic_res3", 64'(d), 64'h0);
        @(negedge clk);
        check("rdv_idle", 64'(bus0.readdatavalid), 64'd0);
        check("rdata_hold", 64'(bus0.read_data), 64'h0);

        // full width, irq_en set together with start
        wr(4'd0, 16'hFFFF, s);
        wr(4'd1, 16'hFFFF, s);
        wr(4'd2, 16'hFFFF, s);
        wr(4'd3, 16'hFFFF, s);
        wr(4'd8, 16'h0005, s);
        check("irq_low_at_start", 64'(irq0), 64'd0);
        n = 0;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (irq0) seen = 1;
        end
        check("done_edges", 64'(n), 64'd32);
        rd(4'd4, d); check("full_res0", 64'(d), 64'h0001);
        rd(4'd5, d); check("full_res1", 64'(d), 64'h0000);
        rd(4'd6, d); check("full_res2", 64'(d), 64'hFFFE);
        rd(4'd7, d); check("full_res3", 64'(d), 64'hFFFF);

        // done_clr keeps irq_en, drops irq
        wr(4'd8, 16'h0006, s);
        check("irq_cleared", 64'(irq0), 64'd0);
        rd(4'd9, d); check("status_cleared", 64'(d), 64'h0);
        rd(4'd8, d); check("ctrl_irq_en", 64'(d), 64'h4);

        // restart with stalled RES read right behind it
        wr(4'd0, 16'h5678, s);
        wr(4'd1, 16'h1234, s);
        wr(4'd2, 16'h0010, s);
        wr(4'd3, 16'h0000, s);
        wr(4'd8, 16'h0005, s);
        rdx(4'd4, 1'b0, d, s);
        check("stall_cycles", 64'(s), 64'd32);
        check("stall_res0", 64'(d), 64'h6780);
        check("restart_irq", 64'(irq0), 64'd1);
        rd(4'd5, d); check("stall_res1", 64'(d), 64'h2345);
        rd(4'd6, d); check("stall_res2", 64'(d), 64'h0001);
        rd(4'd8, d); check("restart_irq_en", 64'(d), 64'h4);

        // reset in the middle of an operation
        wr(4'd8, 16'h0005, s);
        rdx(4'd9, 1'b0, d, s);
        check("busy_status", 64'(d), 64'h1);
        check("busy_status_stall", 64'(s), 64'd0);
        repeat (8) @(negedge clk);
        _rst = 1'b0;
        @(negedge clk);
        _rst = 1'b1;
        check("midrst_irq", 64'(irq0), 64'd0);
        check("midrst_rdata", 64'(bus0.read_data), 64'd0);
        rd(4'd9, d); check("midrst_status", 64'(d), 64'h0);
        rd(4'd4, d); check("midrst_res0", 64'(d), 64'h0);
        repeat (40) @(negedge clk);
        rd(4'd9, d); check("midrst_no_done", 64'(d), 64'h0);
        check("midrst_irq_late", 64'(irq0), 64'd0);

        // edge cases
        rd(4'd15, d); check("unmapped_rd", 64'(d), 64'h0);
        wr(4'd0, 16'hABCD, s);
        rdx(4'd0, 1'b1, d, s);
        check("rw_collision", 64'(d), 64'hABCD);
        rd(4'd0, d); check("rw_a_unchanged", 64'(d), 64'hABCD);
        wr(4'd4, 16'h5555, s);
        rd(4'd4, d); check("res_write_ignored", 64'(d), 64'h0);

        // 64-bit operands on a 32-bit bus: 2^63 * 2
        wr1(4'd0, 32'h0000_0000);
        wr1(4'd1, 32'h8000_0000);
        wr1(4'd2, 32'h0000_0002);
        wr1(4'd3, 32'h0000_0000);
        wr1(4'd8, 32'h0000_0001);
        repeat (70) @(negedge clk);
        rd1(4'd9, d1); check("w64_status", 64'(d1), 64'h2);
        rd1(4'd4, d1); check("w64_res0", 64'(d1), 64'h0);
        rd1(4'd5, d1); check("w64_res1", 64'(d1), 64'h0);
        rd1(4'd6, d1); check("w64_res2", 64'(d1), 64'h1);
        rd1(4'd7, d1); check("w64_res3", 64'(d1), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
